// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and helpers for the RAM port arbiter and its picker.
// State encoding plus a width helper for the ptr/owner registers.
package ram_port_arbiter_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

    localparam int LCNT_W = 8;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted req scanning from ptr upward,
// wrapping modulo NREQ. Returns a one-hot grant and its index.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   idx,
    output logic            any
);

    always_comb begin
        int j;
        j   = 0;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(ptr) + k) % NREQ;
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = PW'(j);
            end
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one block-RAM port among NREQ requesters,
// with bounded lock bursts and a registered per-requester read-valid strobe.
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int DWIDTH   = 32,
    parameter int AWIDTH   = 10,
    parameter int NREQ     = 4,
    parameter int MAX_LOCK = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        r_w,
    input  logic [NREQ-1:0]        lock,
    input  logic [NREQ*AWIDTH-1:0] addr,
    input  logic [NREQ*DWIDTH-1:0] wdata,
    output logic [NREQ-1:0]        gnt,
    output logic [NREQ-1:0]        rvalid,
    output logic [DWIDTH-1:0]      rdata,
    output logic                   ram_ce,
    output logic                   ram_r_w,
    output logic [AWIDTH-1:0]      ram_addr,
    output logic [DWIDTH-1:0]      ram_datain,
    input  logic [DWIDTH-1:0]      ram_dataout
);

    localparam int PW = clog2(NREQ);

    arb_state_t          state_q, state_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [PW-1:0]       owner_q, owner_d;
    logic [LCNT_W-1:0]   lcnt_q, lcnt_d;

    logic [NREQ-1:0]     pick_gnt;
    logic [PW-1:0]       pick_idx;
    logic                pick_any;
    logic [NREQ-1:0]     gnt_raw;
    logic [PW-1:0]       gnt_idx;
    logic [NREQ-1:0]     xfer;
    logic                xfer_any;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req  (req),
        .ptr  (ptr_q),
        .gnt  (pick_gnt),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    // In LOCKED the owner keeps the grant even when it is not requesting.
    always_comb begin
        gnt_raw = pick_gnt;
        gnt_idx = pick_idx;
        if (state_q == ST_LOCKED) begin
            gnt_raw          = '0;
            gnt_raw[owner_q] = 1'b1;
            gnt_idx          = owner_q;
        end
    end

    assign gnt      = rst ? '0 : gnt_raw;
    assign xfer     = req & gnt;
    assign xfer_any = |xfer;
    assign ram_ce   = xfer_any;
    assign rdata    = ram_dataout;

    always_comb begin
        ram_r_w    = 1'b0;
        ram_addr   = '0;
        ram_datain = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                ram_r_w    = r_w[i];
                ram_addr   = addr[i*AWIDTH +: AWIDTH];
                ram_datain = wdata[i*DWIDTH +: DWIDTH];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        lcnt_d  = lcnt_q;
        if (xfer_any) begin
            ptr_d = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);
        end
        unique case (state_q)
            ST_IDLE: begin
                // With MAX_LOCK of 1 the first locked access already exhausts the budget.
                if (xfer_any && lock[gnt_idx] && (MAX_LOCK > 1)) begin
                    state_d = ST_LOCKED;
                    owner_d = gnt_idx;
                    lcnt_d  = LCNT_W'(1);
                end
            end
            ST_LOCKED: begin
                if (xfer_any) begin
                    lcnt_d = lcnt_q + LCNT_W'(1);
                    if (!lock[owner_q] || (lcnt_q + LCNT_W'(1) >= LCNT_W'(MAX_LOCK))) begin
                        state_d = ST_IDLE;
                        lcnt_d  = '0;
                    end
                end else if (!lock[owner_q]) begin
                    state_d = ST_IDLE;
                    lcnt_d  = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            lcnt_q  <= '0;
            rvalid  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            lcnt_q  <= lcnt_d;
            rvalid  <= xfer & ~r_w;
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: a reference model predicts grants and
// read returns; a separate monitor pops expected reads when rvalid appears.
module tb_ram_port_arbiter;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int NR = 4;
    localparam int ML = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NR-1:0]       req = '0;
    logic [NR-1:0]       r_w = '0;
    logic [NR-1:0]       lock = '0;
    logic [NR*AW-1:0]    addr_f = '0;
    logic [NR*DW-1:0]    wdata_f = '0;
    logic [NR-1:0]       gnt;
    logic [NR-1:0]       rvalid;
    logic [DW-1:0]       rdata;
    logic                ram_ce;
    logic                ram_r_w;
    logic [AW-1:0]       ram_addr;
    logic [DW-1:0]       ram_datain;
    logic [DW-1:0]       ram_dataout;

    always #5 clk = ~clk;

    ram_port_arbiter #(
        .DWIDTH   (DW),
        .AWIDTH   (AW),
        .NREQ     (NR),
        .MAX_LOCK (ML)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .r_w         (r_w),
        .lock        (lock),
        .addr        (addr_f),
        .wdata       (wdata_f),
        .gnt         (gnt),
        .rvalid      (rvalid),
        .rdata       (rdata),
        .ram_ce      (ram_ce),
        .ram_r_w     (ram_r_w),
        .ram_addr    (ram_addr),
        .ram_datain  (ram_datain),
        .ram_dataout (ram_dataout)
    );

    function automatic logic [DW-1:0] init_word(input int i);
        if (i == 5) return 32'hDEADBEEF;
        return (32'h9E3779B9 * i) ^ 32'h5A5A0000;
    endfunction

    // Registered-read RAM port.
    logic [DW-1:0] ram_mem [0:(1<<AW)-1];
    initial begin
        ram_dataout = '0;
        for (int i = 0; i < (1 << AW); i++) ram_mem[i] = init_word(i);
        forever begin
            @(posedge clk);
            if (ram_ce) begin
                if (ram_r_w) ram_mem[ram_addr] = ram_datain;
                else         ram_dataout = ram_mem[ram_addr];
            end
        end
    end

    typedef struct {
        int          who;
        logic [DW-1:0] data;
    } rd_t;

    rd_t           exp_q[$];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    bit            m_locked;
    int            m_owner, m_ptr, m_cnt;
    logic [NR-1:0] last_gnt;
    int            n_cmp = 0;
    int            n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare this cycle's combinational outputs with the model, then advance the model.
    task automatic check_cycle();
        int g;
        bit xf;
        logic [NR-1:0] eg;
        logic [AW-1:0] a;
        if (rst) begin
            chk("rst_gnt", gnt, 0);
            chk("rst_ce", ram_ce, 0);
            return;
        end
        g = -1;
        if (m_locked) g = m_owner;
        else
            for (int k = 0; k < NR; k++)
                if (g < 0 && req[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
        eg = '0;
        if (g >= 0) eg[g] = 1'b1;
        last_gnt = gnt;
        chk("gnt", gnt, eg);
        xf = (g >= 0) && req[g];
        chk("ram_ce", ram_ce, xf);
        if (xf) begin
            a = addr_f[g*AW +: AW];
            chk("ram_r_w", ram_r_w, r_w[g]);
            chk("ram_addr", ram_addr, a);
            if (r_w[g]) begin
                chk("ram_datain", ram_datain, wdata_f[g*DW +: DW]);
                ref_mem[a] = wdata_f[g*DW +: DW];
            end else begin
                exp_q.push_back('{g, ref_mem[a]});
            end
            m_ptr = (g + 1) % NR;
        end
        if (!m_locked) begin
            if (xf && lock[g] && ML > 1) begin
                m_locked = 1;
                m_owner  = g;
                m_cnt    = 1;
            end
        end else if (xf) begin
            m_cnt++;
            if (!lock[g] || m_cnt >= ML) m_locked = 0;
        end else if (!lock[m_owner]) begin
            m_locked = 0;
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic enter_reset();
        rst = 1'b1;
        exp_q.delete();
        m_locked = 0;
        m_ptr    = 0;
        m_owner  = 0;
        m_cnt    = 0;
        #1;
        chk("rst_rvalid", rvalid, 0);
        chk("rst_gnt_now", gnt, 0);
        chk("rst_ce_now", ram_ce, 0);
    endtask

    task automatic do_reset();
        enter_reset();
        step();
        rst = 1'b0;
    endtask

    task automatic clear_all();
        req = '0; r_w = '0; lock = '0; addr_f = '0; wdata_f = '0;
    endtask

    task automatic set_one(input int i, input bit rq, input bit rw, input bit lk,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[i]              = rq;
        r_w[i]              = rw;
        lock[i]             = lk;
        addr_f[i*AW +: AW]  = a;
        wdata_f[i*DW +: DW] = d;
    endtask

    // Monitor: every rvalid must match the oldest predicted read, and vice versa.
    initial begin
        rd_t e;
        forever begin
            @(posedge clk);
            #2;
            if (rvalid != '0) begin
                if (exp_q.size() == 0) begin
                    chk("rvalid_unexpected", rvalid, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rvalid", rvalid, 64'(1) << e.who);
                    chk("rdata", rdata, e.data);
                end
            end else if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rvalid_missing", rvalid, 64'(1) << e.who);
            end
        end
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = init_word(i);
        req = '1;
        do_reset();
        clear_all();

        // single read of word 5
        set_one(2, 1, 0, 0, 10'd5, '0);
        step();
        chk("single_gnt", last_gnt, 4'b0100);
        clear_all();
        chk("single_rvalid", rvalid, 4'b0100);
        chk("single_rdata", rdata, 32'hDEADBEEF);
        step();

        // round-robin fairness from reset
        do_reset();
        for (int i = 0; i < NR; i++) set_one(i, 1, 0, 0, AW'($urandom_range(0, 63)), '0);
        for (int c = 0; c < 8; c++) begin
            step();
            chk("rr_order", last_gnt, 64'(1) << (c % 4));
        end
        clear_all();
        step();

        // write then read the top address
        set_one(1, 1, 1, 0, 10'h3FF, 32'h12345678);
        step();
        clear_all();
        set_one(3, 1, 0, 0, 10'h3FF, '0);
        step();
        clear_all();
        chk("wr_rd_rvalid", rvalid, 4'b1000);
        chk("wr_rd_data", rdata, 32'h12345678);
        step();

        // lock burst with an idle owner cycle; requester 1 waits throughout
        do_reset();
        set_one(1, 1, 0, 0, 10'd7, '0);
        set_one(0, 1, 0, 1, 10'd20, '0);
        step();
        chk("burst_gnt0", last_gnt, 4'b0001);
        step();
        set_one(0, 0, 0, 1, 10'd20, '0);
        step();
        chk("burst_idle_gnt", last_gnt, 4'b0001);
        set_one(0, 1, 1, 0, 10'd21, 32'hCAFEF00D);
        step();
        set_one(0, 0, 0, 0, '0, '0);
        step();
        chk("burst_next_gnt", last_gnt, 4'b0010);
        clear_all();
        step();

        // lock timeout at MAX_LOCK
        do_reset();
        set_one(2, 1, 0, 1, 10'd30, '0);
        set_one(3, 1, 0, 0, 10'd31, '0);
        for (int c = 0; c < ML; c++) begin
            step();
            chk("timeout_owner", last_gnt, 4'b0100);
        end
        step();
        chk("timeout_release", last_gnt, 4'b1000);
        clear_all();
        step();
        step();

        // async reset between a read transfer and its rvalid cycle
        set_one(2, 1, 0, 0, 10'd9, '0);
        step();
        req = '1;
        r_w = '0;
        enter_reset();
        step();
        rst = 1'b0;
        step();
        chk("post_reset_prio", last_gnt, 4'b0001);
        clear_all();
        step();

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NR; i++)
                set_one(i, $urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1,
                        $urandom_range(0, 3) == 0, AW'($urandom_range(0, 15)), $urandom);
            step();
        end
        clear_all();
        for (int c = 0; c < ML + 2; c++) step();
        chk("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Round-robin arbiter that shares one port of the team's single-clock dual-port block RAM among NREQ requesters. Each requester presents a one-word access with a req/gnt handshake. The arbiter drives the RAM port's ce, r_w, addr and datain, then returns read data with a per-requester valid strobe one cycle later. Optional lock support lets one requester own the port for a bounded burst (read-modify-write, block copy).

## Interface
Parameters:
- DWIDTH, 32: data width; matches the RAM.
- AWIDTH, 10: address width; matches the RAM.
- NREQ, 4: number of requesters, 2..8.
- MAX_LOCK, 16: maximum consecutive locked accesses before forced release, 1..255.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset; asynchronous, active-high.
- req  in  NREQ  per-requester access request.
- r_w  in  NREQ  per-requester direction; 1 = write, 0 = read.
- lock  in  NREQ  per-requester request to keep ownership after this access.
- addr  in  NREQ*AWIDTH  flattened addresses; requester i uses bits [i*AWIDTH +: AWIDTH].
- wdata  in  NREQ*DWIDTH  flattened write data, packed the same way.
- gnt  out  NREQ  one-hot grant, combinational.
- rvalid  out  NREQ  one-hot, registered; read data valid for requester i.
- rdata  out  DWIDTH  shared read data; equals ram_dataout.
- ram_ce  out  1  RAM port chip enable.
- ram_r_w  out  1  RAM port write enable.
- ram_addr  out  AWIDTH  RAM port address.
- ram_datain  out  DWIDTH  RAM port write data.
- ram_dataout  in  DWIDTH  RAM port registered read data.

## Operation
- Transfer: requester i transfers in a cycle when req[i] and gnt[i] are both high. At most one gnt bit is high per cycle.
- ram_ce = |(req & gnt). ram_r_w, ram_addr and ram_datain are muxed from the granted requester. They are 0 when no bit is granted.
- State machine, two states:
  - IDLE: gnt goes to the first asserted req scanning ptr, ptr+1, … mod NREQ. After a transfer by requester i, ptr <= (i+1) mod NREQ. If lock[i] was high at that transfer, go to LOCKED with owner <= i and lcnt <= 1.
  - LOCKED: gnt[owner] = 1 and all other gnt bits are 0, whether or not req[owner] is high. Cycles with no owner request leave ram_ce = 0.
  - LOCKED, owner transfer with lock low: return to IDLE.
  - LOCKED, owner transfer with lock high: lcnt increments. When lcnt reaches MAX_LOCK, that transfer completes and the arbiter returns to IDLE regardless of lock.
  - LOCKED, owner holds req low and lock low: return to IDLE after that cycle.
  - ptr updates after every owner transfer, as in IDLE.
- Reads: rvalid[i] <= transfer_i & ~r_w[i], registered. rdata is valid in the cycle rvalid[i] is high.
- Writes complete at the transfer edge; there is no acknowledge beyond gnt.
- Requester input changes without a grant are ignored. There is no queueing inside the arbiter.

## Timing
- Reset values: state IDLE, ptr 0, owner 0, lcnt 0, rvalid 0. During reset, gnt = 0 and ram_ce = 0; the combinational outputs are forced low.
- Grant latency: 0 cycles; gnt is combinational from req and state.
- Read latency: the transfer happens on edge N; rvalid and rdata are valid during cycle N+1.
- Back-to-back reads from different requesters produce rvalid on consecutive cycles, one per read.
- Worst-case wait for a requester in IDLE: NREQ-1 transfers. With locks, the bound is (NREQ-1)*MAX_LOCK transfers.
- Reset asserted mid-burst: LOCKED is abandoned immediately. A pending rvalid is cleared and not delivered.
- Simultaneous requests from all NREQ requesters in IDLE with ptr=k: grant goes to k.
- ptr wrap: after a grant to NREQ-1, ptr becomes 0.

## Structure
- Shared package holds the state encoding (ST_IDLE, ST_LOCKED) and a clog2 helper for the ptr/owner width. lcnt is 8 bits.
- One natural sub-module: rr_pick, a combinational round-robin priority picker taking req and ptr and returning a one-hot grant and its index. It is reusable by other arbiters in the design.
- Top: state registers, mux to the RAM port, rvalid register.

## Test plan
- Single read: reset, then RAM word 5 = 0xDEADBEEF, req[2]=1, r_w=0, addr=5 for one cycle -> gnt[2] in that cycle; next cycle rvalid=4'b0100, rdata=0xDEADBEEF.
- Round-robin fairness: req=4'b1111 held for 8 cycles from reset -> grant order 0,1,2,3,0,1,2,3; ram_ce=1 in every cycle.
- Write then read, same address: requester 1 writes 0x12345678 to addr 0x3FF, requester 3 then reads 0x3FF -> rdata=0x12345678 with rvalid[3]. Address 0x3FF checks the top of the address range.
- Lock burst: requester 0 issues 3 accesses with lock=1 while req[1]=1 throughout, 1 idle owner cycle in between, last access lock=0 -> gnt[1] stays low until the burst ends, then requester 1 is granted next.
- Lock timeout: MAX_LOCK=4, requester 2 holds req=1 and lock=1 -> exactly 4 consecutive grants to 2, then a grant to the pending requester 3.
- Async reset mid-read: assert rst between a read transfer and its rvalid cycle -> rvalid=0, gnt=0 and ram_ce=0 immediately; after release, requester 0 has priority.
